// File: rtl/mux_n_sel_reg.sv
// N-way WIDTH-bit select mux with registered output, stall/flush and
// illegal-select detection. Optional counter under MUX_SEL_ERR_CNT_EN.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   in_bus    NUM_IN*WIDTH packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel       binary index of the selected input
//   en        select/data valid this cycle
//   stall     hold all registered state
//   flush     insert a bubble (wins over stall and en)
//   out       registered selected data
//   out_valid out holds data captured from a legal select
//   sel_err   one-cycle pulse per illegal select edge
//   err_cnt   saturating illegal-select count (MUX_SEL_ERR_CNT_EN),
//             tied to zero when the macro is undefined
module mux_n_sel_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [15:0]             err_cnt
);

  localparam int LP_SLOTS = 2 ** SEL_W;

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num
    $error("NUM_IN must be 2..16");
  end
  if (LP_SLOTS < NUM_IN) begin : g_bad_sel
    $error("SEL_W too narrow for NUM_IN");
  end

  // Pad the input array to a full power of two so the index never
  // leaves the array; padded slots are never captured.
  logic [WIDTH-1:0] w_in [LP_SLOTS];

  for (genvar k = 0; k < LP_SLOTS; k++) begin : g_in
    if (k < NUM_IN) begin : g_real
      assign w_in[k] = in_bus[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_in[k] = '0;
    end
  end

  logic w_illegal;

  if (NUM_IN == LP_SLOTS) begin : g_full
    assign w_illegal = 1'b0;
  end else begin : g_part
    localparam logic [SEL_W:0] LP_NUM = NUM_IN[SEL_W:0];
    assign w_illegal = ({1'b0, sel} >= LP_NUM);
  end

  logic w_adv;
  logic w_load;
  logic w_bad;

  assign w_adv  = !flush && !stall;
  assign w_load = w_adv && en && !w_illegal;
  assign w_bad  = w_adv && en && w_illegal;

  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (stall) begin
      r_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out <= w_in[sel];
      end
      r_valid <= w_load;
      r_err   <= w_bad;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign sel_err   = r_err;

`ifdef MUX_SEL_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  // Saturates at all-ones; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_bad && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_n_sel_reg.sv
// Scoreboard bench for mux_n_sel_reg: a 3-input and a 4-input instance
// share control inputs; expected values are pushed per step, monitor pops.
module tb_mux_n_sel_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        en, stall, flush;
  logic [31:0] a [4];

  logic [95:0]  bus3;
  logic [127:0] bus4;
  assign bus3 = {a[2], a[1], a[0]};
  assign bus4 = {a[3], a[2], a[1], a[0]};

  logic [31:0] o3, o4;
  logic        v3, v4, e3, e4;
  logic [15:0] c3, c4;

  always #5 clk = ~clk;

  mux_n_sel_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u3 (
    .clk(clk), .reset(reset), .in_bus(bus3), .sel(sel), .en(en),
    .stall(stall), .flush(flush), .out(o3), .out_valid(v3),
    .sel_err(e3), .err_cnt(c3)
  );

  mux_n_sel_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u4 (
    .clk(clk), .reset(reset), .in_bus(bus4), .sel(sel), .en(en),
    .stall(stall), .flush(flush), .out(o4), .out_valid(v4),
    .sel_err(e4), .err_cnt(c4)
  );

  typedef struct {
    logic [31:0] o3;
    logic        v3;
    logic        e3;
    logic [15:0] c3;
    logic [31:0] o4;
    logic        v4;
    string       nm;
  } exp_t;

  exp_t sb[$];
  event ev;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [15:0] ec(int n);
`ifdef MUX_SEL_ERR_CNT_EN
    return 16'(n);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(ev);
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        x = sb.pop_front();
        chk({x.nm, ".o3"}, o3, x.o3);
        chk({x.nm, ".v3"}, 32'(v3), 32'(x.v3));
        chk({x.nm, ".e3"}, 32'(e3), 32'(x.e3));
        chk({x.nm, ".c3"}, 32'(c3), 32'(x.c3));
        chk({x.nm, ".o4"}, o4, x.o4);
        chk({x.nm, ".v4"}, 32'(v4), 32'(x.v4));
        chk({x.nm, ".e4"}, 32'(e4), 32'h0);
        chk({x.nm, ".c4"}, 32'(c4), 32'h0);
      end
    end
  end

  task automatic push(string nm, logic [31:0] xo3, logic xv3, logic xe3,
                      logic [15:0] xc3, logic [31:0] xo4, logic xv4);
    exp_t x;
    x.o3 = xo3; x.v3 = xv3; x.e3 = xe3; x.c3 = xc3;
    x.o4 = xo4; x.v4 = xv4; x.nm = nm;
    sb.push_back(x);
    ->ev;
  endtask

  task automatic step(string nm, logic [1:0] s, logic e, logic st,
                      logic fl, logic [31:0] xo3, logic xv3, logic xe3,
                      logic [15:0] xc3, logic [31:0] xo4, logic xv4);
    sel = s; en = e; stall = st; flush = fl;
    @(posedge clk);
    #1;
    push(nm, xo3, xv3, xe3, xc3, xo4, xv4);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    sel = 2'd0; en = 1'b0; stall = 1'b0; flush = 1'b0;
    a[0] = 32'd11; a[1] = 32'd22; a[2] = 32'd33; a[3] = 32'd44;
    #12 reset = 1'b0;
    #1 push("rst", 0, 0, 0, 0, 0, 0);
    #1;
    step("sel2",   2'd2, 1, 0, 0, 33, 1, 0, ec(0), 33, 1);
    step("sel0",   2'd0, 1, 0, 0, 11, 1, 0, ec(0), 11, 1);
    step("sel1",   2'd1, 1, 0, 0, 22, 1, 0, ec(0), 22, 1);
    step("ill_a",  2'd3, 1, 0, 0, 22, 0, 1, ec(1), 44, 1);
    step("ill_b",  2'd3, 1, 0, 0, 22, 0, 1, ec(2), 44, 1);
    step("ill_c",  2'd3, 1, 0, 0, 22, 0, 1, ec(3), 44, 1);
    step("en0",    2'd3, 0, 0, 0, 22, 0, 0, ec(3), 44, 0);
    step("ld44",   2'd3, 1, 0, 0, 22, 0, 1, ec(4), 44, 1);
    a[0] = 32'd55; a[1] = 32'd66; a[2] = 32'd77; a[3] = 32'd88;
    step("stall",  2'd0, 1, 1, 0, 22, 0, 0, ec(4), 44, 1);
    step("st_ill", 2'd3, 1, 1, 0, 22, 0, 0, ec(4), 44, 1);
    step("st_fl",  2'd1, 1, 1, 1, 0,  0, 0, ec(4), 0,  0);
    step("newdat", 2'd1, 1, 0, 0, 66, 1, 0, ec(4), 66, 1);
    step("fl_ill", 2'd3, 1, 0, 1, 0,  0, 0, ec(4), 0,  0);
    step("ill_d",  2'd3, 1, 0, 0, 0,  0, 1, ec(5), 88, 1);
    step("recov",  2'd0, 1, 0, 0, 55, 1, 0, ec(5), 55, 1);
    #2 reset = 1'b1;
    #1 push("arst", 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    step("post",   2'd2, 1, 0, 0, 77, 1, 0, ec(0), 77, 1);
`ifdef MUX_SEL_ERR_CNT_EN
    sel = 2'd3; en = 1'b1;
    repeat (65536) @(posedge clk);
    #2;
    step("sat",    2'd3, 1, 0, 0, 77, 0, 1, 16'hFFFF, 88, 1);
    step("sat_fl", 2'd3, 1, 0, 1, 0,  0, 0, 16'hFFFF, 0,  0);
`endif
    for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
